apb_master: RTL and testbench

- APB3 requester (initiator) that converts single read/write commands from an internal host port into APB transfers toward APB slaves.
- Drives the SETUP/ACCESS phase sequence, waits on PREADY, and captures PRDATA/PSLVERR.
- Returns one response per command on a valid/ready response port.
- Sits between the SoC control logic and the APB slave bus segment; one outstanding transfer at a time.

---
 rtl/apb_master.sv | 124 ++++++++++++
 tb/tb_apb_master.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB3 requester: turns single host read/write commands into APB SETUP/ACCESS transfers.
// Define APB_MASTER_APB4_EN to add the APB4 PSTRB/PPROT signals.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
`ifdef APB_MASTER_APB4_EN
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    // A zero timeout still needs a 1-bit counter to keep the declaration legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY
                         && (32'(wait_cnt) == 32'(TIMEOUT_CYCLES - 1));

    assign cmd_ready = (state == IDLE);
    assign PSELx     = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // PREADY is checked before the timeout so a slave answering on the last allowed cycle completes normally.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
`ifdef APB_MASTER_APB4_EN
            PSTRB       <= '0;
            PPROT       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE   <= cmd_write;
                        PADDR    <= cmd_addr;
                        PWDATA   <= cmd_wdata;
                        wait_cnt <= '0;
`ifdef APB_MASTER_APB4_EN
                        PSTRB    <= cmd_write ? cmd_strb : '0;
                        PPROT    <= cmd_prot;
`endif
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a slave model driven per scenario and a response scoreboard.
// Define APB_MASTER_APB4_EN to also exercise the PSTRB/PPROT signals.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
`ifdef APB_MASTER_APB4_EN
    logic [DW/8-1:0] cmd_strb;
    logic [2:0]      cmd_prot;
    logic [DW/8-1:0] PSTRB;
    logic [2:0]      PPROT;
`endif
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
`ifdef APB_MASTER_APB4_EN
        .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .PSTRB(PSTRB),
        .PPROT(PPROT),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSELx(PSELx),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Scoreboard: every response handshake is compared with the oldest expected response.
    always @(negedge PCLK) begin
        #2;
        if (!PRESET && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got rsp rdata=%h err=%b tmo=%b, want no response",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_rdata, rsp_err, rsp_timeout} !== {mon_e.rdata, mon_e.err, mon_e.tmo}) begin
                    errors++;
                    $display("[TB] FAIL sb_rsp: got rdata=%h err=%b tmo=%b, want rdata=%h err=%b tmo=%b",
                             rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.tmo);
                end
            end
        end
    end

    // Called at a falling edge in IDLE; returns at the falling edge of the SETUP cycle.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output bit accepted);
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                accepted = 1'b1;
                @(negedge PCLK);
                break;
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
    endtask

    // Slave model from SETUP: PREADY low for 'waits' ACCESS cycles (negative = never ready).
    task automatic drive_access(input int waits, input logic err_wait, input logic err_ready,
                                input logic [DW-1:0] rdata, output int access, output bit seen);
        access  = 0;
        seen    = 1'b0;
        PREADY  = (waits == 0);
        PSLVERR = (waits == 0) ? err_ready : err_wait;
        PRDATA  = (waits == 0) ? rdata : '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1'b1;
            end else if (PENABLE) begin
                access++;
                if (access == waits) begin
                    PREADY  = 1'b1;
                    PSLVERR = err_ready;
                    PRDATA  = rdata;
                end
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
    endtask

    task automatic test_reset;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++;
        if ({PSELx, PENABLE, rsp_valid, rsp_err, rsp_timeout, PWRITE} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, want 000000",
                     {PSELx, PENABLE, rsp_valid, rsp_err, rsp_timeout, PWRITE});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, want 0", PADDR, PWDATA, rsp_rdata);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_write;
        bit acc;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h12345678;
        rsp_ready = 1'b1;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_accept: got %b, want 1", acc);
        end
        checks++;
        if ({PSELx, PENABLE, PWRITE, cmd_ready, PADDR, PWDATA} !== {4'b1010, 32'h10, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL write_setup: got sel=%b en=%b wr=%b rdy=%b addr=%h wd=%h, want 1 0 1 0 10 deadbeef",
                     PSELx, PENABLE, PWRITE, cmd_ready, PADDR, PWDATA);
        end
        @(negedge PCLK);
        checks++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 32'h10, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL write_access: got sel=%b en=%b wr=%b addr=%h wd=%h, want 1 1 1 10 deadbeef",
                     PSELx, PENABLE, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, PSELx, PENABLE, cmd_ready} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL write_resp: got valid/sel/en/rdy=%b, want 1000",
                     {rsp_valid, PSELx, PENABLE, cmd_ready});
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_idle: got valid/rdy=%b, want 01", {rsp_valid, cmd_ready});
        end
        PREADY = 1'b0;
        PRDATA = '0;
    endtask

    task automatic test_read_wait;
        bit acc;
        bit seen;
        int access;
        exp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
        send_cmd(1'b0, 32'h10, 32'h0BADF00D, acc);
        drive_access(4, 1'b0, 1'b0, 32'hDEADBEEF, access, seen);
        checks++;
        if ({acc, seen} !== 2'b11 || access != 4) begin
            errors++;
            $display("[TB] FAIL read_wait_access: got acc=%b seen=%b access=%0d, want 1 1 4", acc, seen, access);
        end
        @(negedge PCLK);
    endtask

    task automatic test_slverr;
        bit acc;
        bit seen;
        int access;
        exp_q.push_back('{32'hA5A5A5A5, 1'b0, 1'b0});
        send_cmd(1'b0, 32'h14, 32'h0, acc);
        drive_access(3, 1'b1, 1'b0, 32'hA5A5A5A5, access, seen);
        checks++;
        if ({acc, seen} !== 2'b11 || access != 3) begin
            errors++;
            $display("[TB] FAIL slverr_ignored_access: got acc=%b seen=%b access=%0d, want 1 1 3", acc, seen, access);
        end
        @(negedge PCLK);
        exp_q.push_back('{32'h5A5A5A5A, 1'b1, 1'b0});
        send_cmd(1'b0, 32'h18, 32'h0, acc);
        drive_access(2, 1'b0, 1'b1, 32'h5A5A5A5A, access, seen);
        checks++;
        if ({acc, seen} !== 2'b11 || access != 2) begin
            errors++;
            $display("[TB] FAIL slverr_access: got acc=%b seen=%b access=%0d, want 1 1 2", acc, seen, access);
        end
        @(negedge PCLK);
    endtask

    task automatic test_timeout;
        bit acc;
        bit seen;
        int access;
        exp_q.push_back('{32'h0, 1'b1, 1'b1});
        send_cmd(1'b0, 32'h20, 32'h0, acc);
        drive_access(-1, 1'b0, 1'b0, 32'hFFFFFFFF, access, seen);
        checks++;
        if ({acc, seen, PSELx, PENABLE} !== 4'b1100 || access != TO) begin
            errors++;
            $display("[TB] FAIL timeout_access: got acc=%b seen=%b sel=%b en=%b access=%0d, want 1 1 0 0 %0d",
                     acc, seen, PSELx, PENABLE, access, TO);
        end
        @(negedge PCLK);
        // Ready on the cycle the counter would hit the limit must complete normally.
        exp_q.push_back('{32'h11112222, 1'b0, 1'b0});
        send_cmd(1'b0, 32'h24, 32'h0, acc);
        drive_access(TO, 1'b0, 1'b0, 32'h11112222, access, seen);
        checks++;
        if ({acc, seen} !== 2'b11 || access != TO) begin
            errors++;
            $display("[TB] FAIL timeout_boundary: got acc=%b seen=%b access=%0d, want 1 1 %0d", acc, seen, access, TO);
        end
        @(negedge PCLK);
        exp_q.push_back('{32'hCAFEF00D, 1'b0, 1'b0});
        send_cmd(1'b0, 32'h28, 32'h0, acc);
        drive_access(1, 1'b0, 1'b0, 32'hCAFEF00D, access, seen);
        checks++;
        if ({acc, seen} !== 2'b11 || access != 1) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got acc=%b seen=%b access=%0d, want 1 1 1", acc, seen, access);
        end
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back;
        bit acc;
        bit seen;
        int access;
        rsp_ready = 1'b0;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        send_cmd(1'b1, 32'h30, 32'h55, acc);
        drive_access(1, 1'b0, 1'b0, 32'h99999999, access, seen);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({seen, rsp_valid, cmd_ready, PSELx, PENABLE, rsp_err, rsp_timeout} !== 7'b1100000
                || rsp_rdata !== 32'h0 || PADDR !== 32'h30) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got seen/valid/rdy/sel/en/err/tmo=%b rdata=%h addr=%h, want 1100000 0 30",
                         k, {seen, rsp_valid, cmd_ready, PSELx, PENABLE, rsp_err, rsp_timeout}, rsp_rdata, PADDR);
            end
            if (k < 4) @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({cmd_ready, PSELx, rsp_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got rdy/sel/valid=%b, want 100", {cmd_ready, PSELx, rsp_valid});
        end
        exp_q.push_back('{32'h77777777, 1'b0, 1'b0});
        @(negedge PCLK);
        cmd_valid = 1'b0;
        checks++;
        if ({PSELx, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h40) begin
            errors++;
            $display("[TB] FAIL b2b_setup: got sel/en/wr=%b addr=%h, want 100 40", {PSELx, PENABLE, PWRITE}, PADDR);
        end
        drive_access(1, 1'b0, 1'b0, 32'h77777777, access, seen);
        checks++;
        if (seen !== 1'b1 || access != 1) begin
            errors++;
            $display("[TB] FAIL b2b_second: got seen=%b access=%0d, want 1 1", seen, access);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid;
        bit acc;
        PREADY = 1'b0;
        send_cmd(1'b0, 32'h50, 32'h0, acc);
        @(negedge PCLK);
        checks++;
        if ({acc, PSELx, PENABLE} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL midrst_access: got acc/sel/en=%b, want 111", {acc, PSELx, PENABLE});
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b000 || PADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midrst_drop: got sel/en/valid=%b addr=%h, want 000 0", {PSELx, PENABLE, rsp_valid}, PADDR);
        end
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++;
        if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midrst_after: got rdy/valid/sel=%b, want 100", {cmd_ready, rsp_valid, PSELx});
        end
    endtask

`ifdef APB_MASTER_APB4_EN
    task automatic test_apb4;
        bit acc;
        bit seen;
        int access;
        cmd_strb = 4'b0101;
        cmd_prot = 3'b010;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        send_cmd(1'b1, 32'h60, 32'h1234, acc);
        checks++;
        if ({PSTRB, PPROT} !== {4'b0101, 3'b010}) begin
            errors++;
            $display("[TB] FAIL apb4_write_strb: got strb=%b prot=%b, want 0101 010", PSTRB, PPROT);
        end
        drive_access(1, 1'b0, 1'b0, 32'h0, access, seen);
        @(negedge PCLK);
        cmd_strb = 4'b1111;
        cmd_prot = 3'b101;
        exp_q.push_back('{32'h0000ABCD, 1'b0, 1'b0});
        send_cmd(1'b0, 32'h64, 32'h0, acc);
        checks++;
        if ({PSTRB, PPROT} !== {4'b0000, 3'b101}) begin
            errors++;
            $display("[TB] FAIL apb4_read_strb: got strb=%b prot=%b, want 0000 101", PSTRB, PPROT);
        end
        drive_access(1, 1'b0, 1'b0, 32'h0000ABCD, access, seen);
        @(negedge PCLK);
    endtask
`endif

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
`ifdef APB_MASTER_APB4_EN
        cmd_strb  = '0;
        cmd_prot  = '0;
`endif
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        @(negedge PCLK);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_MASTER_APB4_EN
        test_apb4();
`endif
        repeat (2) @(negedge PCLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d pending responses, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
